// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button edge detection, run/pause/expiry FSM,
// load/reset alternation, lap hold and count-enable gating for the BCD counter chain.
module stopwatch_ctrl (
  input  logic        clk,
  input  logic        master_reset,
  input  logic        tick,
  input  logic        button_ss,
  input  logic        button_rl,
  input  logic        up_down,
  input  logic [15:0] q,
  output logic        cnt_reset,
  output logic        cnt_load,
  output logic        cnt_en,
  output logic        dir,
  output logic        done,
  output logic        lap_active,
  output logic [15:0] disp_val,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  typedef enum logic {
    PH_LOAD  = 1'b0,
    PH_RESET = 1'b1
  } phase_t;

  // Bit 0 is start/stop, bit 1 is reset/load/lap.
  logic [1:0] button_raw;
  logic [1:0] press;

  assign button_raw = {button_rl, button_ss};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic sync_reg;
      logic hist_reg;

      always_ff @(posedge clk) begin
        if (master_reset) begin
          sync_reg <= 1'b0;
          hist_reg <= 1'b0;
        end else begin
          sync_reg <= button_raw[gi];
          hist_reg <= sync_reg;
        end
      end

      assign press[gi] = sync_reg & ~hist_reg;
    end
  endgenerate

  logic ss_press;
  logic rl_press;

  // A simultaneous start/stop press swallows the reset/load press.
  assign ss_press = press[0];
  assign rl_press = press[1] & ~press[0];

  state_t      state_reg,      state_next;
  phase_t      phase_reg,      phase_next;
  logic        dir_reg,        dir_next;
  logic [15:0] lap_reg,        lap_next;
  logic        lap_active_reg, lap_active_next;
  logic        cnt_load_reg,   cnt_load_next;
  logic        cnt_reset_reg,  cnt_reset_next;

  logic q_zero;
  logic at_floor;

  assign q_zero   = (q == 16'h0000);
  assign at_floor = ~dir_reg & q_zero;

  always_ff @(posedge clk) begin
    if (master_reset) begin
      state_reg      <= IDLE;
      phase_reg      <= PH_LOAD;
      dir_reg        <= 1'b1;
      lap_reg        <= 16'h0000;
      lap_active_reg <= 1'b0;
      cnt_load_reg   <= 1'b0;
      cnt_reset_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      dir_reg        <= dir_next;
      lap_reg        <= lap_next;
      lap_active_reg <= lap_active_next;
      cnt_load_reg   <= cnt_load_next;
      cnt_reset_reg  <= cnt_reset_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    lap_next        = lap_reg;
    lap_active_next = lap_active_reg;
    cnt_load_next   = 1'b0;
    cnt_reset_next  = 1'b0;
    // Direction is frozen only while counting.
    dir_next        = (state_reg == RUN) ? dir_reg : up_down;

    case (state_reg)
      IDLE, PAUSE: begin
        if (ss_press) begin
          state_next = RUN;
        end else if (rl_press) begin
          if (phase_reg == PH_LOAD) begin
            cnt_load_next = 1'b1;
            state_next    = PAUSE;
            phase_next    = PH_RESET;
          end else begin
            cnt_reset_next = 1'b1;
            state_next     = IDLE;
            phase_next     = PH_LOAD;
          end
        end
      end
      RUN: begin
        // Expiry outranks any button activity in the same cycle.
        if (at_floor) begin
          state_next = EXPIRED;
        end else if (ss_press) begin
          state_next = PAUSE;
        end else if (rl_press) begin
          if (lap_active_reg) begin
            lap_active_next = 1'b0;
          end else begin
            lap_next        = q;
            lap_active_next = 1'b1;
          end
        end
      end
      EXPIRED: begin
        if (rl_press) begin
          cnt_reset_next = 1'b1;
          state_next     = IDLE;
          phase_next     = PH_LOAD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next != RUN) begin
      lap_active_next = 1'b0;
    end
  end

  assign cnt_en     = tick & (state_reg == RUN) & ~at_floor;
  assign cnt_load   = cnt_load_reg;
  assign cnt_reset  = cnt_reset_reg;
  assign dir        = dir_reg;
  assign done       = (state_reg == EXPIRED);
  assign lap_active = lap_active_reg;
  assign disp_val   = lap_active_reg ? lap_reg : q;
  assign state      = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: behavioural controller model plus a BCD counter model
// driving q, directed scenarios with literal checks, then randomized button traffic.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        master_reset = 1'b0;
  logic        tick = 1'b0;
  logic        button_ss = 1'b0;
  logic        button_rl = 1'b0;
  logic        up_down = 1'b1;
  logic [15:0] q = 16'h0000;
  logic        cnt_reset;
  logic        cnt_load;
  logic        cnt_en;
  logic        dir;
  logic        done;
  logic        lap_active;
  logic [15:0] disp_val;
  logic [1:0]  state;

  logic [15:0] load_val = 16'h0000;
  int          n_vec = 0;
  int          n_err = 0;
  bit          checking = 1'b0;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PAUSE = 2;
  localparam int S_EXP  = 3;

  typedef enum {EV_NONE, EV_EXPIRE, EV_START, EV_PAUSE, EV_LAP, EV_LOAD, EV_CLEAR} ev_t;

  // Model of the controller, held as plain facts about the stopwatch.
  int          m_state = S_IDLE;
  bit          m_next_is_clear = 1'b0;
  bit          m_dir = 1'b1;
  logic [15:0] m_lap = 16'h0000;
  bit          m_lap_on = 1'b0;
  bit          m_load = 1'b0;
  bit          m_clr = 1'b0;
  bit          ss_now = 1'b0, ss_prev = 1'b0, rl_now = 1'b0, rl_prev = 1'b0;

  stopwatch_ctrl dut (
    .clk          (clk),
    .master_reset (master_reset),
    .tick         (tick),
    .button_ss    (button_ss),
    .button_rl    (button_rl),
    .up_down      (up_down),
    .q            (q),
    .cnt_reset    (cnt_reset),
    .cnt_load     (cnt_load),
    .cnt_en       (cnt_en),
    .dir          (dir),
    .done         (done),
    .lap_active   (lap_active),
    .disp_val     (disp_val),
    .state        (state)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare outputs mid-cycle, advance model and counter across the edge.
  task automatic cycle();
    bit          ssp, rlp;
    ev_t         ev;
    int          n_state;
    bit          n_phase, n_on, n_dir;
    logic [15:0] n_lap, q_n;
    int          v;
    bit          rst_now;
    @(negedge clk);
    if (checking) begin
      chk("state", 16'(state), 16'(m_state));
      chk("dir", 16'(dir), 16'(m_dir));
      chk("done", 16'(done), 16'(m_state == S_EXP));
      chk("lap_active", 16'(lap_active), 16'(m_lap_on));
      chk("disp_val", disp_val, m_lap_on ? m_lap : q);
      chk("cnt_load", 16'(cnt_load), 16'(m_load));
      chk("cnt_reset", 16'(cnt_reset), 16'(m_clr));
      chk("cnt_en", 16'(cnt_en),
          16'(tick && m_state == S_RUN && !(m_dir == 1'b0 && q == 16'h0000)));
    end

    ssp = ss_now && !ss_prev;
    rlp = rl_now && !rl_prev && !ssp;
    ev  = EV_NONE;
    if (m_state == S_RUN && !m_dir && q == 16'h0000) ev = EV_EXPIRE;
    else if (ssp && m_state != S_EXP) ev = (m_state == S_RUN) ? EV_PAUSE : EV_START;
    else if (rlp) begin
      if (m_state == S_RUN) ev = EV_LAP;
      else if (m_state == S_EXP || m_next_is_clear) ev = EV_CLEAR;
      else ev = EV_LOAD;
    end

    n_state = m_state;
    n_phase = m_next_is_clear;
    n_lap   = m_lap;
    n_on    = m_lap_on;
    case (ev)
      EV_EXPIRE: n_state = S_EXP;
      EV_START:  n_state = S_RUN;
      EV_PAUSE:  n_state = S_PAUSE;
      EV_LAP: begin
        if (m_lap_on) n_on = 1'b0;
        else begin
          n_on  = 1'b1;
          n_lap = q;
        end
      end
      EV_LOAD: begin
        n_state = S_PAUSE;
        n_phase = 1'b1;
      end
      EV_CLEAR: begin
        n_state = S_IDLE;
        n_phase = 1'b0;
      end
      default: ;
    endcase
    if (n_state != S_RUN) n_on = 1'b0;
    n_dir = (m_state == S_RUN) ? m_dir : up_down;

    // Counter chain reacting to the strobes the DUT actually presents.
    v = bcd2int(q);
    if (master_reset || cnt_reset) q_n = 16'h0000;
    else if (cnt_load) q_n = load_val;
    else if (cnt_en) q_n = int2bcd(dir ? (v + 1) % 10000 : (v + 9999) % 10000);
    else q_n = q;

    rst_now = master_reset;
    @(posedge clk);
    #1;
    if (rst_now) begin
      m_state = S_IDLE; m_next_is_clear = 1'b0; m_dir = 1'b1; m_lap = 16'h0000;
      m_lap_on = 1'b0; m_load = 1'b0; m_clr = 1'b0;
      ss_now = 1'b0; ss_prev = 1'b0; rl_now = 1'b0; rl_prev = 1'b0;
      checking = 1'b1;
    end else begin
      m_load  = (ev == EV_LOAD);
      m_clr   = (ev == EV_CLEAR);
      m_state = n_state; m_next_is_clear = n_phase; m_dir = n_dir;
      m_lap   = n_lap;   m_lap_on = n_on;
      ss_prev = ss_now; ss_now = button_ss;
      rl_prev = rl_now; rl_now = button_rl;
    end
    q = q_n;
  endtask

  task automatic press(input bit ss, input bit rl);
    button_ss = ss;
    button_rl = rl;
    cycle();
    cycle();
  endtask

  task automatic unpress();
    button_ss = 1'b0;
    button_rl = 1'b0;
    cycle();
  endtask

  initial begin
    $display("-- reset and start");
    master_reset = 1'b1;
    cycle();
    cycle();
    master_reset = 1'b0;
    chk("rst_state", 16'(state), 16'h0000);
    chk("rst_dir", 16'(dir), 16'h0001);
    chk("rst_load", 16'(cnt_load), 16'h0000);
    chk("rst_reset", 16'(cnt_reset), 16'h0000);
    chk("rst_done", 16'(done), 16'h0000);
    up_down = 1'b1;
    button_ss = 1'b1;
    cycle();
    chk("start_lat1", 16'(state), 16'h0000);
    cycle();
    chk("start_lat2", 16'(state), 16'h0001);
    tick = 1'b1;
    #1;
    chk("run_cnt_en", 16'(cnt_en), 16'h0001);
    cycle(); cycle(); cycle();
    unpress();

    $display("-- pause and resume");
    press(1'b1, 1'b0);
    chk("pause_state", 16'(state), 16'h0002);
    cycle(); cycle(); cycle(); cycle();
    chk("pause_held", 16'(state), 16'h0002);
    #1;
    chk("pause_cnt_en", 16'(cnt_en), 16'h0000);
    unpress();
    press(1'b1, 1'b0);
    chk("resume_state", 16'(state), 16'h0001);
    unpress();
    press(1'b1, 1'b0);
    unpress();
    tick = 1'b0;

    $display("-- load then reset");
    load_val = 16'h0123;
    press(1'b0, 1'b1);
    chk("load_strobe", 16'(cnt_load), 16'h0001);
    chk("load_state", 16'(state), 16'h0002);
    unpress();
    chk("load_drop", 16'(cnt_load), 16'h0000);
    chk("load_q", q, 16'h0123);
    press(1'b0, 1'b1);
    chk("clr_strobe", 16'(cnt_reset), 16'h0001);
    chk("clr_state", 16'(state), 16'h0000);
    unpress();
    chk("clr_q", q, 16'h0000);
    press(1'b0, 1'b1);
    chk("reload_strobe", 16'(cnt_load), 16'h0001);
    unpress();

    $display("-- lap");
    press(1'b1, 1'b0);
    unpress();
    press(1'b0, 1'b1);
    chk("lap_on", 16'(lap_active), 16'h0001);
    chk("lap_disp", disp_val, 16'h0123);
    tick = 1'b1;
    unpress();
    cycle(); cycle(); cycle();
    tick = 1'b0;
    chk("lap_q_moves", q, 16'h0127);
    chk("lap_frozen", disp_val, 16'h0123);
    press(1'b0, 1'b1);
    chk("lap_off_disp", disp_val, 16'h0127);
    unpress();
    press(1'b0, 1'b1);
    unpress();
    press(1'b1, 1'b0);
    chk("pause_clears_lap", 16'(lap_active), 16'h0000);
    unpress();

    $display("-- count-down expiry");
    press(1'b0, 1'b1);
    unpress();
    load_val = 16'h0003;
    press(1'b0, 1'b1);
    unpress();
    up_down = 1'b0;
    cycle();
    tick = 1'b1;
    press(1'b1, 1'b0);
    unpress();
    for (int i = 0; i < 8; i++) cycle();
    chk("exp_state", 16'(state), 16'h0003);
    chk("exp_done", 16'(done), 16'h0001);
    chk("exp_q", q, 16'h0000);
    press(1'b1, 1'b0);
    chk("exp_ss_ignored", 16'(state), 16'h0003);
    unpress();
    press(1'b0, 1'b1);
    chk("exp_clr", 16'(cnt_reset), 16'h0001);
    chk("exp_idle", 16'(state), 16'h0000);
    chk("exp_done_off", 16'(done), 16'h0000);
    unpress();
    tick = 1'b0;
    up_down = 1'b1;

    $display("-- conflicts");
    load_val = 16'h0042;
    press(1'b0, 1'b1);
    unpress();
    press(1'b1, 1'b1);
    chk("both_state", 16'(state), 16'h0001);
    chk("both_no_load", 16'(cnt_load), 16'h0000);
    chk("both_no_clr", 16'(cnt_reset), 16'h0000);
    unpress();
    press(1'b1, 1'b0);
    unpress();
    press(1'b0, 1'b1);
    unpress();
    button_rl = 1'b1;
    cycle();
    master_reset = 1'b1;
    cycle();
    chk("rst_drop_load", 16'(cnt_load), 16'h0000);
    chk("rst_drop_state", 16'(state), 16'h0000);
    master_reset = 1'b0;
    button_rl = 1'b0;
    cycle();

    $display("-- random traffic");
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) button_ss = ~button_ss;
      if ($urandom_range(0, 7) == 0) button_rl = ~button_rl;
      if ($urandom_range(0, 60) == 0 && !button_ss && !button_rl) begin
        button_ss = 1'b1;
        button_rl = 1'b1;
      end
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) up_down = ~up_down;
      master_reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0)
        load_val = ($urandom_range(0, 1) == 0) ? int2bcd($urandom_range(0, 5))
                                               : int2bcd($urandom_range(0, 9999));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
